drum_divider_seq: RTL and testbench



---
 rtl/drum_divider_seq.sv | 203 ++++++++++++++++++++
 tb/tb_drum_divider_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/drum_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : drum_divider_seq
// Description : Sequential approximate unsigned divider (DRUM style). Both
//               operands are cut to K-bit mantissas with leading-one detect,
//               top-K truncation and a forced LSB. The mantissas go through a
//               radix-2 restoring division, and the quotient is rescaled by
//               the exponent difference. Valid/ready on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module drum_divider_seq #(
    parameter int N = 16,
    parameter int K = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         div_by_zero
);

    localparam int c_LW = $clog2(N);          // leading-one position / exponent width
    localparam int c_SW = c_LW + 2;           // signed rescale amount width
    localparam int c_CW = $clog2(2 * K) + 1;  // division step counter width
    localparam int c_QW = 2 * K + N;          // headroom for the left shift

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_DIV   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic [2*K-1:0]    r_d;
    logic [K-1:0]      r_rem;
    logic [2*K-1:0]    r_qf;
    logic [K-1:0]      r_mb;
    logic [c_LW-1:0]   r_ea;
    logic [c_LW-1:0]   r_eb;
    logic [c_CW-1:0]   r_cnt;

    logic [c_LW-1:0]   w_k1;
    logic [c_LW-1:0]   w_k2;
    logic [c_LW-1:0]   w_ea;
    logic [c_LW-1:0]   w_eb;
    logic [K-3:0]      w_ta;
    logic [K-3:0]      w_tb;
    logic [K-1:0]      w_ma;
    logic [K-1:0]      w_mb;
    logic [K:0]        w_rp;
    logic              w_ge;
    logic [K-1:0]      w_rn;
    logic [c_SW-1:0]   w_s;
    logic [c_SW-1:0]   w_mag;
    logic [c_QW-1:0]   w_left;
    logic [2*K-1:0]    w_right;
    logic              w_sat;
    logic [N-1:0]      w_qres;

    // Position of the most significant set bit (0 for an all-zero operand).
    function automatic logic [c_LW-1:0] lod(input logic [N-1:0] x);
        lod = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                lod = c_LW'(i);
            end
        end
    endfunction

    // Mantissa/exponent extraction, one division step and the final rescale.
    always_comb begin
        w_k1 = lod(r_a);
        w_k2 = lod(r_b);

        // Interior bits sit just below the leading one; the LSB is forced high
        // so that dropping the low-order bits is unbiased on average.
        if (w_k1 > c_LW'(K - 1)) begin
            w_ea = w_k1 - c_LW'(K - 1);
            w_ta = (K-2)'(r_a >> (w_k1 - c_LW'(K - 2)));
            w_ma = {1'b1, w_ta, 1'b1};
        end else begin
            w_ea = '0;
            w_ta = '0;
            w_ma = r_a[K-1:0];
        end

        if (w_k2 > c_LW'(K - 1)) begin
            w_eb = w_k2 - c_LW'(K - 1);
            w_tb = (K-2)'(r_b >> (w_k2 - c_LW'(K - 2)));
            w_mb = {1'b1, w_tb, 1'b1};
        end else begin
            w_eb = '0;
            w_tb = '0;
            w_mb = r_b[K-1:0];
        end

        // Remainder stays below mb (< 2^K), so K bits hold it and the
        // shifted-in partial remainder needs only K+1 bits.
        w_rp = {r_rem, r_d[2*K-1]};
        w_ge = (w_rp >= {1'b0, r_mb});
        w_rn = w_ge ? K'(w_rp - {1'b0, r_mb}) : w_rp[K-1:0];

        // s = ea - eb - K in two's complement; shift by its magnitude.
        w_s     = c_SW'(r_ea) - c_SW'(r_eb) - c_SW'(K);
        w_mag   = w_s[c_SW-1] ? (~w_s + c_SW'(1)) : w_s;
        w_left  = c_QW'(r_qf) << w_mag;
        w_right = r_qf >> w_mag;
        w_sat   = |w_left[c_QW-1:N];
        if (w_s[c_SW-1]) begin
            w_qres = N'(w_right);
        end else if (w_sat) begin
            w_qres = '1;
        end else begin
            w_qres = w_left[N-1:0];
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_qf        <= '0;
            r_mb        <= '0;
            r_ea        <= '0;
            r_eb        <= '0;
            r_cnt       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (b == '0) begin
                            q           <= '1;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_a     <= a;
                            r_b     <= b;
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    r_d     <= {w_ma, K'(0)};
                    r_rem   <= '0;
                    r_qf    <= '0;
                    r_mb    <= w_mb;
                    r_ea    <= w_ea;
                    r_eb    <= w_eb;
                    r_cnt   <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_d   <= {r_d[2*K-2:0], 1'b0};
                    r_rem <= w_rn;
                    r_qf  <= {r_qf[2*K-2:0], w_ge};
                    r_cnt <= r_cnt + c_CW'(1);
                    if (r_cnt == c_CW'(2 * K - 1)) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    q           <= w_qres;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_drum_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_drum_divider_seq
// Description : Directed, table-driven bench for drum_divider_seq (N=16, K=6)
//               with hand-computed quotients plus backpressure and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drum_divider_seq;

    localparam int N = 16;
    localparam int K = 6;
    localparam int c_LAT = 2 * K + 2;  // edges after the accepting edge
    localparam int c_TMO = 200;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_q;
        logic         exp_dz;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic         div_by_zero;

    int errors;
    int checks;

    drum_divider_seq #(.N(N), .K(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands, let one edge accept them, then count edges until
    // out_valid appears. Returns -1 on timeout.
    task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, output int lat);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < c_TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            lat = -1;
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[12];
    int   lat;

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        //            a         b        q        dz
        vecs[0]  = '{16'd100,  16'd7,   16'd14,  1'b0};
        vecs[1]  = '{16'd45,   16'd6,   16'd7,   1'b0};
        vecs[2]  = '{16'hFFFF, 16'd1,   16'hFC00,1'b0};
        vecs[3]  = '{16'd1234, 16'd0,   16'hFFFF,1'b1};
        vecs[4]  = '{16'd0,    16'd5,   16'd0,   1'b0};
        vecs[5]  = '{16'd63,   16'd63,  16'd1,   1'b0};
        vecs[6]  = '{16'd1000, 16'd10,  16'd100, 1'b0};
        vecs[7]  = '{16'd5,    16'd9,   16'd0,   1'b0};
        vecs[8]  = '{16'hFFFF, 16'hFFFF,16'd1,   1'b0};
        vecs[9]  = '{16'h8000, 16'd3,   16'h2C00,1'b0};
        vecs[10] = '{16'd200,  16'd100, 16'd2,   1'b0};
        vecs[11] = '{16'd7,    16'd100, 16'd0,   1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_q",         32'(q), 32'd0);
        check("reset_dz",        32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors: quotient, flag and latency for each.
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_q", i),  32'(q), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].exp_dz));
            // Divide by zero: out_valid directly after the accepting edge.
            check($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].exp_dz ? 32'd0 : 32'(c_LAT));
            pop_result();
            check($sformatf("vec%0d_release", i), 32'({out_valid, in_ready}), 32'b01);
        end

        // Backpressure: result held, new operands refused.
        start_op(16'd100, 16'd7, lat);
        check("bp_lat", 32'(lat), 32'(c_LAT));
        for (int c = 0; c < 5; c++) begin
            a        = 16'd9;
            b        = (c == 2) ? 16'd0 : 16'd3;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_q", c),        32'(q), 32'd14);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_out_valid", c),32'(out_valid), 32'd1);
            check($sformatf("bp%0d_dz", c),       32'(div_by_zero), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready), 32'd1);
        // Nothing was queued: no spurious result should follow.
        repeat (2 * K + 6) @(posedge clk);
        #1;
        check("bp_no_queued_op", 32'({out_valid, in_ready}), 32'b01);

        // Reset during DIV aborts asynchronously.
        a        = 16'd100;
        b        = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q",         32'(q), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_idle_out_valid", 32'({out_valid, in_ready}), 32'b01);
        start_op(16'd100, 16'd7, lat);
        check("post_rst_q",   32'(q), 32'd14);
        check("post_rst_lat", 32'(lat), 32'(c_LAT));
        check("post_rst_dz",  32'(div_by_zero), 32'd0);
        pop_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
